// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider returning {remainder, quotient} for HI/LO.
// Optional feature: define DIV_EARLY_EXIT_EN to finish in one edge when |a| < |b|.
module div_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 div_start,
    input  logic                 div_signed,
    input  logic                 div_annul,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   result,
    output logic                 div_ready
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, BYZERO, ON, END} state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]     quo_q, quo_d;
    logic [WIDTH-1:0]     dvs_q, dvs_d;
    logic                 negq_q, negq_d;
    logic                 negr_q, negr_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 ready_q, ready_d;

    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       shifted, trial;
    logic [WIDTH-1:0]     rem_nxt, quo_nxt;

    function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] x);
        return WIDTH'(~x + WIDTH'(1));
    endfunction

    // Operand magnitudes and one restoring step on the 33-bit partial remainder
    always_comb begin
        a_mag   = (div_signed && a[WIDTH-1]) ? neg(a) : a;
        b_mag   = (div_signed && b[WIDTH-1]) ? neg(b) : b;
        shifted = {rem_q, quo_q[WIDTH-1]};
        trial   = shifted - {1'b0, dvs_q};
        if (!trial[WIDTH]) begin
            rem_nxt = trial[WIDTH-1:0];
            quo_nxt = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_nxt = shifted[WIDTH-1:0];
            quo_nxt = {quo_q[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        result_d = result_q;
        ready_d  = ready_q;
        case (state_q)
            IDLE: begin
                if (div_start && !div_annul) begin
                    dvs_d  = b_mag;
                    rem_d  = '0;
                    quo_d  = a_mag;
                    cnt_d  = '0;
                    negq_d = div_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                    negr_d = div_signed & a[WIDTH-1];
                    if (b == '0) begin
                        state_d = BYZERO;
`ifdef DIV_EARLY_EXIT_EN
                    end else if (a_mag < b_mag) begin
                        state_d  = END;
                        result_d = {a, WIDTH'(0)};
                        ready_d  = 1'b1;
`endif
                    end else begin
                        state_d = ON;
                    end
                end
            end
            ON: begin
                // Annul wins over completion of the last iteration
                if (div_annul) begin
                    state_d = IDLE;
                end else begin
                    rem_d = rem_nxt;
                    quo_d = quo_nxt;
                    cnt_d = CW'(cnt_q + CW'(1));
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d  = END;
                        ready_d  = 1'b1;
                        result_d = {negr_q ? neg(rem_nxt) : rem_nxt,
                                    negq_q ? neg(quo_nxt) : quo_nxt};
                    end
                end
            end
            BYZERO: begin
                if (div_annul) begin
                    state_d = IDLE;
                end else begin
                    state_d  = END;
                    result_d = '0;
                    ready_d  = 1'b1;
                end
            end
            END: begin
                if (div_annul || !div_start) begin
                    state_d = IDLE;
                    ready_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    assign result    = result_q;
    assign div_ready = ready_q;

endmodule

// File: tb/tb_div_iter.sv
// Directed table-driven bench for div_iter plus annul, reset and handshake sequences.
module tb_div_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        div_start, div_signed, div_annul;
    logic [31:0] a, b;
    logic [63:0] result;
    logic        div_ready;

    int total = 0;
    int bad   = 0;

    div_iter #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .div_start(div_start), .div_signed(div_signed),
        .div_annul(div_annul), .a(a), .b(b), .result(result), .div_ready(div_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sg;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] res;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic sg, input logic [31:0] av, input logic [31:0] bv);
        logic [31:0] ma, mb;
        ma = (sg && av[31]) ? 32'(-av) : av;
        mb = (sg && bv[31]) ? 32'(-bv) : bv;
        if (bv == 32'd0) return 2;
`ifdef DIV_EARLY_EXIT_EN
        if (ma < mb) return 1;
`endif
        if (ma == mb) return 33;
        return 33;
    endfunction

    // Start a division and count edges (accept edge = 1) until div_ready, bounded
    task automatic run(input logic sg, input logic [31:0] av, input logic [31:0] bv,
                       output logic [63:0] res, output int lat);
        @(negedge clk);
        div_signed = sg; a = av; b = bv; div_start = 1'b1; div_annul = 1'b0;
        lat = 0;
        res = '0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (div_ready) begin
                lat = k;
                res = result;
                break;
            end
        end
    endtask

    task automatic drop_and_check(input string name, input logic [63:0] exp);
        @(negedge clk);
        div_start = 1'b0;
        @(posedge clk); #1;
        chk({name, "_ready_low"}, 64'(div_ready), 64'd0);
        chk({name, "_result_kept"}, result, exp);
    endtask

    initial begin
        logic [63:0] res;
        int          lat;
        int          highs;

        vecs[0]  = '{1'b0, 32'd100,        32'd7,          {32'd2,          32'd14}};
        vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          {32'hFFFFFFFF,   32'hFFFFFFFD}};
        vecs[2]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   {32'd1,          32'hFFFFFFFD}};
        vecs[3]  = '{1'b0, 32'h00001234,   32'd0,          64'h0};
        vecs[4]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   {32'd0,          32'h80000000}};
        vecs[5]  = '{1'b0, 32'd5,          32'd9,          {32'd5,          32'd0}};
        vecs[6]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          {32'd0,          32'hFFFFFFFF}};
        vecs[7]  = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   {32'd0,          32'd1}};
        vecs[8]  = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   {32'hFFFFFFFE,   32'd14}};
        vecs[9]  = '{1'b0, 32'h80000000,   32'd3,          {32'd2,          32'h2AAAAAAA}};
        vecs[10] = '{1'b1, 32'hFFFFFFFB,   32'd9,          {32'hFFFFFFFB,   32'd0}};
        vecs[11] = '{1'b0, 32'd0,          32'd5,          64'h0};

        rst = 1'b1; div_start = 1'b0; div_signed = 1'b0; div_annul = 1'b0; a = '0; b = '0;
        #12;
        chk("reset_ready", 64'(div_ready), 64'd0);
        chk("reset_result", result, 64'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run(vecs[i].sg, vecs[i].a, vecs[i].b, res, lat);
            chk($sformatf("v%0d_result", i), res, vecs[i].res);
            chk($sformatf("v%0d_latency", i), 64'(lat), 64'(exp_lat(vecs[i].sg, vecs[i].a, vecs[i].b)));
            drop_and_check($sformatf("v%0d", i), vecs[i].res);
        end

        // div_start held through END: result and ready hold, no restart
        run(1'b0, 32'd100, 32'd7, res, lat);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("hold_ready", 64'(div_ready), 64'd1);
            chk("hold_result", result, {32'd2, 32'd14});
        end
        drop_and_check("hold", {32'd2, 32'd14});

        // Start with annul in IDLE is ignored (b=0 would otherwise raise ready in 2 edges)
        @(negedge clk);
        div_signed = 1'b0; a = 32'h1234; b = 32'd0; div_start = 1'b1; div_annul = 1'b1;
        highs = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (div_ready) highs++;
        end
        chk("idle_annul_ignored", 64'(highs), 64'd0);
        @(negedge clk);
        div_start = 1'b0; div_annul = 1'b0;

        // Annul at iteration 10 of 0xFFFFFFFF/3: ready never rises, result untouched
        @(negedge clk);
        div_signed = 1'b0; a = 32'hFFFFFFFF; b = 32'd3; div_start = 1'b1;
        repeat (11) @(posedge clk);
        @(negedge clk);
        div_annul = 1'b1; div_start = 1'b0;
        @(negedge clk);
        div_annul = 1'b0;
        highs = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (div_ready) highs++;
        end
        chk("annul_on_no_ready", 64'(highs), 64'd0);
        chk("annul_on_result", result, {32'd2, 32'd14});
        run(1'b0, 32'd9, 32'd3, res, lat);
        chk("after_annul_result", res, {32'd0, 32'd3});
        chk("after_annul_latency", 64'(lat), 64'd33);

        // Annul while in END drops ready on the next edge
        @(negedge clk);
        div_annul = 1'b1;
        @(posedge clk); #1;
        chk("annul_end_ready", 64'(div_ready), 64'd0);
        chk("annul_end_result", result, {32'd0, 32'd3});
        @(negedge clk);
        div_annul = 1'b0; div_start = 1'b0;

        // Annul in BYZERO: no END
        @(negedge clk);
        a = 32'h55; b = 32'd0; div_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        div_annul = 1'b1; div_start = 1'b0;
        @(negedge clk);
        div_annul = 1'b0;
        highs = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (div_ready) highs++;
        end
        chk("annul_byzero_no_ready", 64'(highs), 64'd0);

        // Asynchronous reset at iteration 20 clears outputs before the next edge
        @(negedge clk);
        div_signed = 1'b0; a = 32'hFFFFFFFF; b = 32'd3; div_start = 1'b1;
        repeat (21) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_ready", 64'(div_ready), 64'd0);
        chk("async_rst_result", result, 64'h0);
        div_start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        run(1'b1, 32'h80000000, 32'hFFFFFFFF, res, lat);
        chk("post_rst_result", res, {32'd0, 32'h80000000});
        chk("post_rst_latency", 64'(lat), 64'd33);
        drop_and_check("post_rst", {32'd0, 32'h80000000});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
